// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified instruction/data RAM between the fetch stage
// (read-only) and the memory stage (load/store). Each access runs through a
// fixed sequence IDLE -> ISSUE -> WAIT -> RESP, so accesses never overlap and
// the RAM sees exactly one ram_en cycle per access.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request, held until if_valid
//   if_flush            kills the in-flight fetch response (wrong path)
//   if_valid/if_rdata   one-cycle fetch response
//   mem_req/mem_we/
//   mem_addr/mem_wdata  load/store request, held until mem_valid
//   mem_valid/mem_rdata one-cycle load/store response (rdata 0 on stores)
//   ram_en/ram_we/
//   ram_addr/ram_wdata  registered RAM command, ram_en one cycle per access
//   ram_rdata           RAM read data, valid LATENCY cycles after ram_en
//   pipe_stall          combinational stall while a requester is waiting
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 2,
  parameter int AW         = 16,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_valid,
  output logic [DW-1:0] mem_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          pipe_stall
);

  // Counter widths are kept at least one bit so degenerate parameter values
  // (LATENCY == 1, MAX_STREAK == 0) still elaborate cleanly.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [SW-1:0]   streak_r;
  logic [SW-1:0]   streak_nxt_s;
  logic            owner_if_r;
  logic            store_r;
  logic            flush_r;
  logic            grant_if_s;
  logic            grant_mem_s;
  logic            cnt_zero_s;

  logic            if_valid_r;
  logic [DW-1:0]   if_rdata_r;
  logic            mem_valid_r;
  logic [DW-1:0]   mem_rdata_r;
  logic            ram_en_r;
  logic            ram_we_r;
  logic [AW-1:0]   ram_addr_r;
  logic [DW-1:0]   ram_wdata_r;

  assign cnt_zero_s = (cnt_r == {CW{1'b0}});

  // Arbitration: only meaningful in IDLE. MEM normally wins a tie; once MEM
  // has won MAX_STREAK times in a row against a waiting fetch, IF wins.
  always_comb begin
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (if_req && mem_req) begin
        if ((MAX_STREAK != 0) && (streak_r >= STREAK_MAX)) begin
          grant_if_s = 1'b1;
        end else begin
          grant_mem_s = 1'b1;
        end
      end else if (if_req) begin
        grant_if_s = 1'b1;
      end else if (mem_req) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
      end
    end else begin
      grant_if_s  = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  // Streak update: counts MEM wins that made a fetch wait, saturating.
  always_comb begin
    streak_nxt_s = streak_r;
    if (grant_if_s) begin
      streak_nxt_s = {SW{1'b0}};
    end else if (grant_mem_s) begin
      if (!if_req) begin
        streak_nxt_s = {SW{1'b0}};
      end else if (streak_r >= STREAK_MAX) begin
        streak_nxt_s = STREAK_MAX;
      end else begin
        streak_nxt_s = streak_r + SW'(1'b1);
      end
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_if_s || grant_mem_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_zero_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Access datapath: latches the winner, drives the RAM command, counts the
  // read latency, captures read data and produces the one-cycle responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      streak_r    <= {SW{1'b0}};
      owner_if_r  <= 1'b0;
      store_r     <= 1'b0;
      flush_r     <= 1'b0;
      if_valid_r  <= 1'b0;
      if_rdata_r  <= {DW{1'b0}};
      mem_valid_r <= 1'b0;
      mem_rdata_r <= {DW{1'b0}};
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {DW{1'b0}};
    end else begin
      // Strobes are single-cycle; they are only raised by the cases below.
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      if_valid_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      streak_r    <= streak_nxt_s;
      case (state_r)
        ST_IDLE: begin
          flush_r <= 1'b0;
          if (grant_if_s) begin
            owner_if_r  <= 1'b1;
            store_r     <= 1'b0;
            ram_en_r    <= 1'b1;
            ram_addr_r  <= if_addr;
            ram_wdata_r <= {DW{1'b0}};
          end else if (grant_mem_s) begin
            owner_if_r  <= 1'b0;
            store_r     <= mem_we;
            ram_en_r    <= 1'b1;
            ram_we_r    <= mem_we;
            ram_addr_r  <= mem_addr;
            ram_wdata_r <= mem_wdata;
          end else begin
            owner_if_r  <= owner_if_r;
          end
        end
        ST_ISSUE: begin
          cnt_r <= CNT_LOAD;
          if (owner_if_r && if_flush) begin
            flush_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (owner_if_r && if_flush) begin
            flush_r <= 1'b1;
          end
          if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CW'(1'b1);
          end else if (owner_if_r) begin
            // A flush seen in this very cycle must also suppress the response.
            if (!(flush_r || if_flush)) begin
              if_rdata_r <= ram_rdata;
              if_valid_r <= 1'b1;
            end
          end else begin
            mem_rdata_r <= store_r ? {DW{1'b0}} : ram_rdata;
            mem_valid_r <= 1'b1;
          end
        end
        ST_RESP: begin
          flush_r <= 1'b0;
        end
        default: begin
          flush_r <= 1'b0;
        end
      endcase
    end
  end

  assign if_valid   = if_valid_r;
  assign if_rdata   = if_rdata_r;
  assign mem_valid  = mem_valid_r;
  assign mem_rdata  = mem_rdata_r;
  assign ram_en     = ram_en_r;
  assign ram_we     = ram_we_r;
  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign pipe_stall = (if_req & ~if_valid_r) | (mem_req & ~mem_valid_r);

endmodule
